banco_reg_param: RTL and testbench
==================================

Name: banco_reg_param

Overview:
- Parametrised successor to the uniciclo register bank: integer register file with configurable data width, register count and number of combinational read ports.
- Adds an asynchronous active-low reset that restores architectural init values (SP, GP).
- Adds a sequential scrub engine that re-initialises the whole bank on request, a debug read port, and a last-write debug register.
- Sits between decode and ALU in the uniciclo/multiciclo datapaths.

Parameters:
- DATA_W, 32, register width in bits.
- NREGS, 32, number of registers; power of two, >= 4.
- ADDR_W, 5, index width; must equal log2(NREGS).
- NRD, 2, number of read ports.
- SP_IDX, 2, stack-pointer register index.
- SP_INIT, 1020, SP value after reset or scrub.
- GP_IDX, 3, global-pointer register index.
- GP_INIT, 32'h0000_1800, GP value after reset or scrub.

Ports:
- iCLK  in  1  clock; all state changes on the rising edge.
- iRSTn  in  1  asynchronous active-low reset.
- iRegWrite  in  1  write enable.
- iWriteRegister  in  ADDR_W  write index.
- iWriteData  in  DATA_W  write data.
- iRs  in  NRD*ADDR_W  packed read indices; port k uses bits [k*ADDR_W +: ADDR_W].
- oDado  out  NRD*DATA_W  packed read data; port k uses bits [k*DATA_W +: DATA_W].
- iClear  in  1  scrub request, sampled on the clock edge.
- oBusy  out  1  high while the scrub engine is running.
- oWriteDrop  out  1  one-cycle pulse when a write is rejected.
- iDbgSel  in  ADDR_W  debug read index.
- oDbgData  out  DATA_W  combinational read of register iDbgSel.
- oDebug  out  DATA_W  registered copy of the last accepted write data.

Behaviour:
- Reset (iRSTn=0, asynchronous, takes effect immediately):
  - All registers cleared to 0, except BR[SP_IDX]=SP_INIT and BR[GP_IDX]=GP_INIT.
  - oDebug=0, oBusy=0, oWriteDrop=0, FSM=IDLE, scrub pointer=0.
- Reset has priority over every other event, including mid-scrub; the scrub is abandoned and the bank is in the reset state.
- Register 0:
  - Reads as 0 on every port, including the debug port.
  - Writes to index 0 are silently discarded: no oDebug update, no oWriteDrop.
- Reads:
  - oDado port k = BR[iRs[k]], combinational, zero latency.
  - oDbgData = BR[iDbgSel], combinational, zero latency.
- Write acceptance, in IDLE:
  - Condition: iRegWrite=1 and iWriteRegister != 0.
  - Effect on the edge: BR[iWriteRegister] <= iWriteData and oDebug <= iWriteData.
  - Visible on the read ports the following cycle (without BYPASS_EN).
- FSM states: IDLE, SCRUB.
  - IDLE -> SCRUB: iClear=1 at an edge. The pointer loads 1 and oBusy rises that same edge.
  - A write presented on the same edge as iClear is still accepted. The scrub later overwrites it.
  - SCRUB, each edge: BR[ptr] <= init(ptr), ptr <= ptr+1. init(ptr) is SP_INIT at SP_IDX, GP_INIT at GP_IDX, otherwise 0.
  - SCRUB -> IDLE: on the edge that writes ptr = NREGS-1. oBusy falls on that same edge.
  - Scrub duration: exactly NREGS-1 cycles of oBusy=1 (31 for the defaults).
  - iClear while in SCRUB is ignored; the scrub does not restart.
- Writes during SCRUB:
  - Not performed; oDebug is unchanged.
  - oWriteDrop=1 for the cycle following the rejected request (registered pulse).
  - Exception: index 0 never asserts oWriteDrop.
- Reads during SCRUB return the current array contents, a mix of scrubbed and unscrubbed entries.
- Width rules:
  - Data is stored unmodified, with no sign handling.
  - Indices are unsigned; with ADDR_W = log2(NREGS) no index is out of range.

Optional Feature:
- Macro: BANCO_REG_BYPASS_EN.
- Defined:
  - Write-to-read forwarding on every oDado port and on oDbgData.
  - If iRegWrite=1, the index matches, the index != 0 and FSM=IDLE, the port returns iWriteData in the same cycle.
  - Forwarding is inactive during SCRUB.
- Undefined:
  - Ports return the stored value.
  - Read-during-write to the same index returns the old data.

Test Plan:
- Reset values: deassert iRSTn -> oDado[0] with iRs=2 reads 1020; iRs=3 reads 0x1800; iRs=10 reads 0; oDebug=0; oBusy=0.
- Write/read and x0: write 0xDEADBEEF to x10 -> x10 reads 0xDEADBEEF next cycle and oDebug=0xDEADBEEF. Then write 0x1234 to x0 -> x0 still reads 0, oDebug unchanged, oWriteDrop=0.
- Scrub: fill x1..x31 with 0xA5A5_0000+i, pulse iClear.
  - oBusy high exactly 31 cycles.
  - Afterwards x2=1020, x3=0x1800, all other registers 0.
  - A second iClear at cycle 10 of the scrub is ignored (still 31 cycles).
- Write during scrub: iRegWrite to x5 with 0x77 at scrub cycle 3 -> oWriteDrop pulses once, x5=0 after the scrub, oDebug unchanged.
- Reset mid-scrub: assert iRSTn=0 at scrub cycle 12 -> oBusy=0 immediately, reset values present, and a write immediately after release is accepted.
- Bypass and parameters: with BANCO_REG_BYPASS_EN, write 0x55 to x7 while iRs=7 -> oDado reads 0x55 in the same cycle; without the macro it reads the old value.
  - Repeat the suite with DATA_W=64, NREGS=16, NRD=3.

Source files
------------

// File: rtl/banco_reg_param_if.sv
// Bus bundle for banco_reg_param: write port, packed read ports, scrub control and debug taps.
interface banco_reg_param_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NRD    = 2
);
  logic                     iRegWrite;
  logic [ADDR_W-1:0]        iWriteRegister;
  logic [DATA_W-1:0]        iWriteData;
  logic [NRD*ADDR_W-1:0]    iRs;
  logic [NRD*DATA_W-1:0]    oDado;
  logic                     iClear;
  logic                     oBusy;
  logic                     oWriteDrop;
  logic [ADDR_W-1:0]        iDbgSel;
  logic [DATA_W-1:0]        oDbgData;
  logic [DATA_W-1:0]        oDebug;

  modport master (
    output iRegWrite, iWriteRegister, iWriteData, iRs, iClear, iDbgSel,
    input  oDado, oBusy, oWriteDrop, oDbgData, oDebug
  );

  modport slave (
    input  iRegWrite, iWriteRegister, iWriteData, iRs, iClear, iDbgSel,
    output oDado, oBusy, oWriteDrop, oDbgData, oDebug
  );
endinterface

// File: rtl/banco_reg_param.sv
// Parametrised integer register bank with async reset to SP/GP init values, sequential scrub engine,
// debug read port and last-write debug register. Optional write-to-read forwarding: BANCO_REG_BYPASS_EN.
module banco_reg_param #(
  parameter int unsigned       DATA_W  = 32,
  parameter int unsigned       NREGS   = 32,
  parameter int unsigned       ADDR_W  = 5,
  parameter int unsigned       NRD     = 2,
  parameter int unsigned       SP_IDX  = 2,
  parameter logic [DATA_W-1:0] SP_INIT = DATA_W'(1020),
  parameter int unsigned       GP_IDX  = 3,
  parameter logic [DATA_W-1:0] GP_INIT = DATA_W'(32'h0000_1800)
) (
  input  logic             iCLK,
  input  logic             iRSTn,
  banco_reg_param_if.slave bus
);

  typedef enum logic {IDLE, SCRUB} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   ptr;
  logic [DATA_W-1:0]   br [NREGS];
  logic                busy_q;
  logic                drop_q;
  logic [DATA_W-1:0]   debug_q;
  logic                wr_ok_c;
  logic [NRD*DATA_W-1:0] dado_c;
  logic [DATA_W-1:0]   dbg_c;

  // Architectural value of a register after reset or scrub.
  function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] idx);
    if (idx == ADDR_W'(SP_IDX)) return SP_INIT;
    if (idx == ADDR_W'(GP_IDX)) return GP_INIT;
    return '0;
  endfunction

  assign wr_ok_c = bus.iRegWrite && (bus.iWriteRegister != '0);

  // State, scrub pointer, register array and registered status outputs.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state   <= IDLE;
      ptr     <= '0;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
      debug_q <= '0;
      for (int i = 0; i < int'(NREGS); i++) br[ADDR_W'(i)] <= init_val(ADDR_W'(i));
    end else begin
      drop_q <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_ok_c) begin
            br[bus.iWriteRegister] <= bus.iWriteData;
            debug_q                <= bus.iWriteData;
          end
          if (bus.iClear) begin
            state  <= SCRUB;
            ptr    <= ADDR_W'(1);
            busy_q <= 1'b1;
          end
        end
        SCRUB: begin
          br[ptr] <= init_val(ptr);
          ptr     <= ptr + ADDR_W'(1);
          drop_q  <= wr_ok_c;
          if (ptr == ADDR_W'(NREGS - 1)) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Single read path shared by every data port and the debug port; x0 is hard-wired to zero.
  function automatic logic [DATA_W-1:0] rd_fn(input logic [ADDR_W-1:0] idx);
    logic [DATA_W-1:0] v;
    v = (idx == '0) ? '0 : br[idx];
`ifdef BANCO_REG_BYPASS_EN
    if ((state == IDLE) && wr_ok_c && (idx == bus.iWriteRegister)) v = bus.iWriteData;
`endif
    return v;
  endfunction

  always_comb begin
    dado_c = '0;
    for (int k = 0; k < int'(NRD); k++) begin
      dado_c[k*DATA_W +: DATA_W] = rd_fn(bus.iRs[k*ADDR_W +: ADDR_W]);
    end
    dbg_c = rd_fn(bus.iDbgSel);
  end

  assign bus.oDado      = dado_c;
  assign bus.oDbgData   = dbg_c;
  assign bus.oBusy      = busy_q;
  assign bus.oWriteDrop = drop_q;
  assign bus.oDebug     = debug_q;

endmodule

// File: tb/tb_banco_reg_param.sv
// Randomised self-checking bench for banco_reg_param against a behavioural register-bank model.
module tb_banco_reg_param;

  localparam int unsigned       DATA_W  = 32;
  localparam int unsigned       NREGS   = 32;
  localparam int unsigned       ADDR_W  = 5;
  localparam int unsigned       NRD     = 2;
  localparam int unsigned       SP_IDX  = 2;
  localparam int unsigned       GP_IDX  = 3;
  localparam logic [DATA_W-1:0] SP_INIT = DATA_W'(1020);
  localparam logic [DATA_W-1:0] GP_INIT = DATA_W'(32'h0000_1800);
`ifdef BANCO_REG_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic iCLK;
  logic iRSTn;
  int   total;
  int   bad;

  logic [DATA_W-1:0] model [NREGS];
  logic [DATA_W-1:0] mdebug;

  banco_reg_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NRD(NRD)) bus ();

  banco_reg_param #(
    .DATA_W(DATA_W), .NREGS(NREGS), .ADDR_W(ADDR_W), .NRD(NRD),
    .SP_IDX(SP_IDX), .SP_INIT(SP_INIT), .GP_IDX(GP_IDX), .GP_INIT(GP_INIT)
  ) dut (
    .iCLK (iCLK),
    .iRSTn(iRSTn),
    .bus  (bus)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  function automatic void model_init();
    for (int i = 0; i < int'(NREGS); i++) model[i] = '0;
    model[SP_IDX] = SP_INIT;
    model[GP_IDX] = GP_INIT;
  endfunction

  // Expected read value: x0 is zero, forwarding only when enabled and idle, otherwise stored data.
  function automatic logic [DATA_W-1:0] exp_rd(input int idx, input bit wr, input int widx,
                                                input logic [DATA_W-1:0] wd, input bit idle);
    if (idx == 0) return '0;
    if (BYP && wr && idle && (idx == widx)) return wd;
    return model[idx];
  endfunction

  function automatic logic [DATA_W-1:0] rnd_data();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return DATA_W'(r);
  endfunction

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic set_rs(input int idx);
    for (int k = 0; k < int'(NRD); k++) bus.iRs[k*ADDR_W +: ADDR_W] = ADDR_W'(idx);
  endtask

  task automatic do_write(input int idx, input logic [DATA_W-1:0] d);
    bus.iRegWrite      = 1'b1;
    bus.iWriteRegister = ADDR_W'(idx);
    bus.iWriteData     = d;
    tick();
    bus.iRegWrite = 1'b0;
    if (idx != 0) begin
      model[idx] = d;
      mdebug     = d;
    end
  endtask

  task automatic test_reset();
    iRSTn = 1'b0;
    repeat (2) tick();
    iRSTn = 1'b1;
    model_init();
    mdebug = '0;
    tick();
    total++;
    if (bus.oBusy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.oBusy); end
    total++;
    if (bus.oWriteDrop !== 1'b0) begin bad++; $display("FAIL reset_drop got=%b exp=0", bus.oWriteDrop); end
    total++;
    if (bus.oDebug !== '0) begin bad++; $display("FAIL reset_debug got=%h exp=0", bus.oDebug); end
    for (int i = 0; i < int'(NREGS); i++) begin
      set_rs(i);
      bus.iDbgSel = ADDR_W'(i);
      #1;
      total++;
      if (bus.oDbgData !== model[i]) begin
        bad++; $display("FAIL reset_dbg x%0d got=%h exp=%h", i, bus.oDbgData, model[i]);
      end
      for (int k = 0; k < int'(NRD); k++) begin
        total++;
        if (bus.oDado[k*DATA_W +: DATA_W] !== model[i]) begin
          bad++; $display("FAIL reset_port%0d x%0d got=%h exp=%h", k, i, bus.oDado[k*DATA_W +: DATA_W], model[i]);
        end
      end
    end
  endtask

  task automatic test_write_read();
    logic [DATA_W-1:0] e;
    tick();
    set_rs(10);
    bus.iRegWrite = 1'b1; bus.iWriteRegister = ADDR_W'(10); bus.iWriteData = DATA_W'(32'hDEAD_BEEF);
    #1;
    e = exp_rd(10, 1'b1, 10, DATA_W'(32'hDEAD_BEEF), 1'b1);
    total++;
    if (bus.oDado[DATA_W-1:0] !== e) begin bad++; $display("FAIL wr_same_cycle got=%h exp=%h", bus.oDado[DATA_W-1:0], e); end
    tick();
    bus.iRegWrite = 1'b0;
    model[10] = DATA_W'(32'hDEAD_BEEF); mdebug = DATA_W'(32'hDEAD_BEEF);
    #1;
    total++;
    if (bus.oDado[DATA_W-1:0] !== model[10]) begin bad++; $display("FAIL wr_next_cycle got=%h exp=%h", bus.oDado[DATA_W-1:0], model[10]); end
    total++;
    if (bus.oDebug !== mdebug) begin bad++; $display("FAIL wr_debug got=%h exp=%h", bus.oDebug, mdebug); end
    // x0 write: discarded, no debug update, no drop
    set_rs(0);
    bus.iDbgSel = '0;
    bus.iRegWrite = 1'b1; bus.iWriteRegister = '0; bus.iWriteData = DATA_W'(32'h1234);
    #1;
    total++;
    if (bus.oDado[DATA_W-1:0] !== '0) begin bad++; $display("FAIL x0_same_cycle got=%h exp=0", bus.oDado[DATA_W-1:0]); end
    tick();
    bus.iRegWrite = 1'b0;
    for (int k = 0; k < int'(NRD); k++) begin
      total++;
      if (bus.oDado[k*DATA_W +: DATA_W] !== '0) begin bad++; $display("FAIL x0_port%0d got=%h exp=0", k, bus.oDado[k*DATA_W +: DATA_W]); end
    end
    total++;
    if (bus.oDbgData !== '0) begin bad++; $display("FAIL x0_dbg got=%h exp=0", bus.oDbgData); end
    total++;
    if (bus.oDebug !== mdebug) begin bad++; $display("FAIL x0_debug got=%h exp=%h", bus.oDebug, mdebug); end
    total++;
    if (bus.oWriteDrop !== 1'b0) begin bad++; $display("FAIL x0_drop got=%b exp=0", bus.oWriteDrop); end
  endtask

  task automatic test_random();
    int rs [NRD];
    int dsel, widx;
    bit wr;
    logic [DATA_W-1:0] wd, e;
    for (int n = 0; n < 300; n++) begin
      wr = 1'($urandom_range(0, 1));
      widx = int'($urandom_range(0, NREGS - 1));
      wd = rnd_data();
      dsel = (n % 4 == 0) ? widx : int'($urandom_range(0, NREGS - 1));
      for (int k = 0; k < int'(NRD); k++) begin
        rs[k] = (n % 3 == k) ? widx : int'($urandom_range(0, NREGS - 1));
        bus.iRs[k*ADDR_W +: ADDR_W] = ADDR_W'(rs[k]);
      end
      bus.iDbgSel = ADDR_W'(dsel);
      bus.iRegWrite = wr; bus.iWriteRegister = ADDR_W'(widx); bus.iWriteData = wd;
      #1;
      for (int k = 0; k < int'(NRD); k++) begin
        e = exp_rd(rs[k], wr, widx, wd, 1'b1);
        total++;
        if (bus.oDado[k*DATA_W +: DATA_W] !== e) begin
          bad++; $display("FAIL rnd_port%0d n=%0d x%0d got=%h exp=%h", k, n, rs[k], bus.oDado[k*DATA_W +: DATA_W], e);
        end
      end
      e = exp_rd(dsel, wr, widx, wd, 1'b1);
      total++;
      if (bus.oDbgData !== e) begin bad++; $display("FAIL rnd_dbg n=%0d x%0d got=%h exp=%h", n, dsel, bus.oDbgData, e); end
      tick();
      if (wr && widx != 0) begin model[widx] = wd; mdebug = wd; end
      total++;
      if (bus.oDebug !== mdebug) begin bad++; $display("FAIL rnd_debug n=%0d got=%h exp=%h", n, bus.oDebug, mdebug); end
      total++;
      if (bus.oWriteDrop !== 1'b0 || bus.oBusy !== 1'b0) begin
        bad++; $display("FAIL rnd_status n=%0d got=%b%b exp=00", n, bus.oWriteDrop, bus.oBusy);
      end
    end
    bus.iRegWrite = 1'b0;
  endtask

  task automatic test_scrub();
    int cnt, guard;
    for (int i = 1; i < int'(NREGS); i++) do_write(i, DATA_W'(32'hA5A5_0000 + i));
    // write on the clear edge is still accepted
    bus.iClear = 1'b1;
    bus.iRegWrite = 1'b1; bus.iWriteRegister = ADDR_W'(4); bus.iWriteData = DATA_W'(32'hCAFE);
    tick();
    bus.iClear = 1'b0; bus.iRegWrite = 1'b0;
    mdebug = DATA_W'(32'hCAFE);
    total++;
    if (bus.oDebug !== mdebug) begin bad++; $display("FAIL clear_edge_write got=%h exp=%h", bus.oDebug, mdebug); end
    cnt = 0; guard = 0;
    while (bus.oBusy === 1'b1 && guard < 4 * int'(NREGS)) begin
      cnt++;
      if (cnt == 10) bus.iClear = 1'b1;
      tick();
      bus.iClear = 1'b0;
      guard++;
    end
    total++;
    if (cnt != int'(NREGS) - 1) begin bad++; $display("FAIL scrub_len got=%0d exp=%0d", cnt, NREGS - 1); end
    model_init();
    for (int i = 0; i < int'(NREGS); i++) begin
      set_rs(i);
      bus.iDbgSel = ADDR_W'(i);
      #1;
      total++;
      if (bus.oDbgData !== model[i]) begin bad++; $display("FAIL scrub_dbg x%0d got=%h exp=%h", i, bus.oDbgData, model[i]); end
      total++;
      if (bus.oDado[(NRD-1)*DATA_W +: DATA_W] !== model[i]) begin
        bad++; $display("FAIL scrub_port x%0d got=%h exp=%h", i, bus.oDado[(NRD-1)*DATA_W +: DATA_W], model[i]);
      end
    end
    total++;
    if (bus.oDebug !== mdebug) begin bad++; $display("FAIL scrub_debug got=%h exp=%h", bus.oDebug, mdebug); end
  endtask

  task automatic test_write_during_scrub();
    int cnt, guard, drops;
    tick();
    do_write(5, DATA_W'(32'h99));
    bus.iClear = 1'b1;
    tick();
    bus.iClear = 1'b0;
    cnt = 0; guard = 0; drops = 0;
    while (bus.oBusy === 1'b1 && guard < 4 * int'(NREGS)) begin
      cnt++;
      if (cnt == 3) begin
        bus.iRegWrite = 1'b1; bus.iWriteRegister = ADDR_W'(5); bus.iWriteData = DATA_W'(32'h77);
        bus.iDbgSel = ADDR_W'(5);
        #1;
        total++;
        if (bus.oDbgData !== model[5]) begin bad++; $display("FAIL scrub_no_fwd got=%h exp=%h", bus.oDbgData, model[5]); end
      end
      if (cnt == 6) begin
        bus.iRegWrite = 1'b1; bus.iWriteRegister = '0; bus.iWriteData = DATA_W'(32'h66);
      end
      tick();
      bus.iRegWrite = 1'b0;
      if (bus.oWriteDrop === 1'b1) drops++;
      if (cnt == 3) begin
        total++;
        if (bus.oWriteDrop !== 1'b1) begin bad++; $display("FAIL drop_pulse got=%b exp=1", bus.oWriteDrop); end
      end
      if (cnt == 4 || cnt == 6) begin
        total++;
        if (bus.oWriteDrop !== 1'b0) begin bad++; $display("FAIL drop_extra cnt=%0d got=%b exp=0", cnt, bus.oWriteDrop); end
      end
      guard++;
    end
    total++;
    if (guard >= 4 * int'(NREGS)) begin bad++; $display("FAIL scrub_timeout got=%0d exp<%0d", guard, 4 * NREGS); end
    total++;
    if (drops != 1) begin bad++; $display("FAIL drop_count got=%0d exp=1", drops); end
    model_init();
    bus.iDbgSel = ADDR_W'(5);
    #1;
    total++;
    if (bus.oDbgData !== '0) begin bad++; $display("FAIL x5_after_scrub got=%h exp=0", bus.oDbgData); end
    total++;
    if (bus.oDebug !== mdebug) begin bad++; $display("FAIL drop_debug got=%h exp=%h", bus.oDebug, mdebug); end
  endtask

  task automatic test_reset_mid_scrub();
    int cnt;
    tick();
    do_write(10, DATA_W'(32'h1234_ABCD));
    bus.iClear = 1'b1;
    tick();
    bus.iClear = 1'b0;
    cnt = 1;
    while (cnt < 12) begin tick(); cnt++; end
    iRSTn = 1'b0;
    model_init();
    mdebug = '0;
    set_rs(10);
    bus.iDbgSel = ADDR_W'(SP_IDX);
    #1;
    total++;
    if (bus.oBusy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b exp=0", bus.oBusy); end
    total++;
    if (bus.oDebug !== '0) begin bad++; $display("FAIL rst_mid_debug got=%h exp=0", bus.oDebug); end
    total++;
    if (bus.oDbgData !== SP_INIT) begin bad++; $display("FAIL rst_mid_sp got=%h exp=%h", bus.oDbgData, SP_INIT); end
    total++;
    if (bus.oDado[DATA_W-1:0] !== '0) begin bad++; $display("FAIL rst_mid_x10 got=%h exp=0", bus.oDado[DATA_W-1:0]); end
    bus.iDbgSel = ADDR_W'(GP_IDX);
    #1;
    total++;
    if (bus.oDbgData !== GP_INIT) begin bad++; $display("FAIL rst_mid_gp got=%h exp=%h", bus.oDbgData, GP_INIT); end
    #2;
    iRSTn = 1'b1;
    do_write(9, DATA_W'(32'h4242));
    bus.iDbgSel = ADDR_W'(9);
    #1;
    total++;
    if (bus.oDbgData !== model[9]) begin bad++; $display("FAIL post_rst_write got=%h exp=%h", bus.oDbgData, model[9]); end
    total++;
    if (bus.oDebug !== mdebug) begin bad++; $display("FAIL post_rst_debug got=%h exp=%h", bus.oDebug, mdebug); end
    total++;
    if (bus.oBusy !== 1'b0) begin bad++; $display("FAIL post_rst_busy got=%b exp=0", bus.oBusy); end
  endtask

  task automatic test_bypass();
    logic [DATA_W-1:0] e;
    tick();
    do_write(7, DATA_W'(32'h11));
    set_rs(7);
    bus.iDbgSel = ADDR_W'(7);
    bus.iRegWrite = 1'b1; bus.iWriteRegister = ADDR_W'(7); bus.iWriteData = DATA_W'(32'h55);
    #1;
    e = exp_rd(7, 1'b1, 7, DATA_W'(32'h55), 1'b1);
    for (int k = 0; k < int'(NRD); k++) begin
      total++;
      if (bus.oDado[k*DATA_W +: DATA_W] !== e) begin
        bad++; $display("FAIL bypass_port%0d got=%h exp=%h", k, bus.oDado[k*DATA_W +: DATA_W], e);
      end
    end
    total++;
    if (bus.oDbgData !== e) begin bad++; $display("FAIL bypass_dbg got=%h exp=%h", bus.oDbgData, e); end
    tick();
    bus.iRegWrite = 1'b0;
    model[7] = DATA_W'(32'h55); mdebug = DATA_W'(32'h55);
    total++;
    if (bus.oDado[DATA_W-1:0] !== model[7]) begin bad++; $display("FAIL bypass_after got=%h exp=%h", bus.oDado[DATA_W-1:0], model[7]); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    iRSTn = 1'b0;
    bus.iRegWrite = 1'b0;
    bus.iWriteRegister = '0;
    bus.iWriteData = '0;
    bus.iRs = '0;
    bus.iClear = 1'b0;
    bus.iDbgSel = '0;
    test_reset();
    test_write_read();
    test_random();
    test_scrub();
    test_write_during_scrub();
    test_reset_mid_scrub();
    test_bypass();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
